key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 Parameter N_KEYS, default 4, number of board push-buttons serviced (1..8).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples required to accept a new level (2..65535).
REQ-003 Parameter FIFO_DEPTH, default 4, event queue entries (power of two, 2..16).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 key_in  input  N_KEYS  raw active-low buttons (0 = pressed), asynchronous to clk.
REQ-007 evt_valid  output  1  queue head holds an event.
REQ-008 evt_ready  input  1  consumer accepts head; pop when evt_valid && evt_ready.
REQ-009 evt_data  output  4  {kind(1: 1=press, 0=release), index(3)}; valid only while evt_valid.
REQ-010 key_state  output  N_KEYS  debounced level per key, 1 = pressed.
REQ-011 ovf  output  1  sticky lost-event flag.
REQ-012 ovf_clr  input  1  single-cycle clear of ovf.

Function
REQ-013 Each key_in bit SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Per key, a counter SHALL increment while the synchronized sample differs from key_state and reset to 0 when it equals key_state.
REQ-015 When the counter reaches DEBOUNCE_CYCLES-1 and the sample still differs, key_state SHALL toggle and the counter SHALL clear in the same cycle.
REQ-016 A key_state toggle SHALL set that key's pending bit and latch its kind; pending with kind=release SHALL only be set when releases are enabled (see REQ-027).
REQ-017 Scheduler: each cycle, if any pending bit is set and the FIFO is not full (or a pop occurs the same cycle), the lowest-index pending key SHALL be pushed and its pending bit cleared.
REQ-018 At most one push and one pop per cycle; simultaneous push and pop on a full FIFO SHALL succeed with occupancy unchanged.
REQ-019 A toggle on a key whose pending bit is already set SHALL overwrite the pending kind and set ovf.
REQ-020 Pop on empty FIFO SHALL be ignored; evt_data SHALL be stable while evt_valid && !evt_ready.
REQ-021 Latency: key_in held stable from cycle 0 on an idle block SHALL give evt_valid high in cycle DEBOUNCE_CYCLES+4.
REQ-022 Bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no toggle and no event.
REQ-023 ovf_clr coincident with a new ovf-setting event SHALL leave ovf set.

Reset
REQ-024 rst_n low SHALL asynchronously clear synchronizers to 1 (released), counters, key_state, pending bits, FIFO pointers, and ovf; evt_valid=0, evt_data=0.
REQ-025 Reset asserted mid-debounce or with queued events SHALL discard all in-flight state; no event SHALL be emitted for keys already held at reset release until they change after a full debounce.
REQ-026 Reset deassertion is synchronized externally; no event SHALL occur in the first 2 cycles after release.

Configuration
REQ-027 Macro KEY_EVENT_RELEASE_EN: defined -> release events queued with kind=0; undefined -> only press events queued, key_state still tracks releases, release toggles never set pending or ovf.

Structure
REQ-028 Package key_event_pkg SHALL hold event-kind constants, the event field widths, and the max N_KEYS/FIFO_DEPTH limits.
REQ-029 One sub-module, key_debounce_ch (synchronizer + counter + key_state + toggle pulse for one key), instantiated N_KEYS times; scheduler and FIFO live in key_event_ctrl.

Verification
REQ-030 Key 2 pressed clean (defaults) -> evt_valid in cycle 20, evt_data=4'b1010, key_state=4'b0100.
REQ-031 Key 0 bounces 0/1 every 5 cycles for 60 cycles then holds 0 -> exactly one press event, index 0.
REQ-032 Keys 1 and 3 settle the same cycle -> events index 1 then index 3 on consecutive cycles, evt_ready=1.
REQ-033 evt_ready=0, six distinct presses on defaults -> 4 queued, 2 pending; release ready -> all 6 delivered in order, ovf=0; repeat with key re-toggling while pending -> ovf=1, cleared by ovf_clr.
REQ-034 Release with KEY_EVENT_RELEASE_EN defined -> evt_data=4'b0xxx; undefined -> no event, key_state bit clears.
REQ-035 rst_n low for 1 cycle with 3 queued events and key held -> evt_valid=0 immediately, no event until key released and re-pressed.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared definitions for the push-button event controller: event field
// layout, event-kind encoding and the supported size limits.
package key_event_pkg;

    localparam int EVT_KIND_W = 1;
    localparam int EVT_IDX_W  = 3;
    localparam int EVT_W      = EVT_KIND_W + EVT_IDX_W;

    localparam int MAX_N_KEYS     = 8;
    localparam int MAX_FIFO_DEPTH = 16;

    typedef enum logic {
        KIND_RELEASE = 1'b0,
        KIND_PRESS   = 1'b1
    } evt_kind_e;

    typedef struct packed {
        evt_kind_e             kind;
        logic [EVT_IDX_W-1:0]  index;
    } evt_t;

    // Build a queue entry from the key's new debounced level and its index.
    function automatic evt_t make_evt(input logic pressed, input logic [EVT_IDX_W-1:0] idx);
        evt_t e;
        e.kind  = evt_kind_e'(pressed);
        e.index = idx;
        return e;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-flop synchronizer, stability counter, debounced
// level and a one-cycle toggle pulse. A channel only reports toggles once it
// has seen its key released after reset, so a key held through reset stays
// silent until it is released and pressed again (its level is still tracked).
module key_debounce_ch
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,     // active-low, asynchronous to clk
    output logic key_level,   // debounced level, 1 = pressed
    output logic toggle       // high for the cycle key_level shows a reportable change
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             toggle_reg;
    logic             armed_reg;
    logic [1:0]       fill_reg;

    logic sample_pressed;
    logic differs;
    logic accept;
    logic fill_done;

    assign sample_pressed = ~sync2_reg;
    assign differs        = (sample_pressed != level_reg);
    assign accept         = differs && (cnt_reg == CNT_LAST);
    assign fill_done      = (fill_reg == 2'd2);

    // Two-stage synchronizer; resets to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= key_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Arm reporting once the synchronizer holds real samples and the key is seen released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_reg  <= 2'd0;
            armed_reg <= 1'b0;
        end else begin
            if (!fill_done)
                fill_reg <= fill_reg + 2'd1;
            if (fill_done && !level_reg && !sample_pressed)
                armed_reg <= 1'b1;
        end
    end

    // Stability counter and debounced level; the toggle pulse lines up with the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            level_reg  <= 1'b0;
            toggle_reg <= 1'b0;
        end else begin
            if (!differs || accept)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 1'b1;
            if (accept)
                level_reg <= sample_pressed;
            toggle_reg <= accept && armed_reg;
        end
    end

    assign key_level = level_reg;
    assign toggle    = toggle_reg;

endmodule

// File: rtl/key_event_ctrl.sv
// Push-button event controller: N_KEYS debounce channels feed per-key pending
// bits; a lowest-index-first scheduler moves one pending event per cycle into
// a small FIFO drained through a valid/ready handshake. Lost events (a new
// toggle on a key whose previous event is still pending) set a sticky ovf.
// Build option: define KEY_EVENT_RELEASE_EN to also queue release events;
// without it only presses are queued while key_state still tracks releases.
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [3:0]        evt_data,
    output logic [N_KEYS-1:0] key_state,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [N_KEYS-1:0] toggle;
    logic [N_KEYS-1:0] report;
    logic [N_KEYS-1:0] pending_reg;
    logic [N_KEYS-1:0] kind_reg;
    logic [N_KEYS-1:0] push_mask;
    logic [N_KEYS-1:0] lost;
    logic              ovf_reg;

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    evt_t              fifo_mem [FIFO_DEPTH];

    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  push;
    logic [EVT_IDX_W-1:0]  push_idx;
    logic                  push_kind;
    evt_t                  push_evt;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_ch
            key_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .key_raw   (key_in[gi]),
                .key_level (key_state[gi]),
                .toggle    (toggle[gi])
            );
        end
    endgenerate

`ifdef KEY_EVENT_RELEASE_EN
    assign report = toggle;
`else
    // Release toggles are invisible to the queue: they neither queue nor overflow.
    assign report = toggle & key_state;
`endif

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
    assign evt_valid = !empty;
    assign pop       = !empty && evt_ready;
    assign push      = (|pending_reg) && (!full || pop);
    assign push_evt  = make_evt(push_kind, push_idx);
    assign lost      = report & pending_reg & ~push_mask;

    // Pick the lowest-index pending key and its latched kind.
    always_comb begin
        push_idx  = '0;
        push_kind = 1'b0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                push_idx  = EVT_IDX_W'(i);
                push_kind = kind_reg[i];
            end
        end
    end

    // One-hot of the key whose pending event leaves this cycle.
    always_comb begin
        push_mask = '0;
        for (int i = 0; i < N_KEYS; i++)
            push_mask[i] = push && (push_idx == EVT_IDX_W'(i));
    end

    // Pending bits, latched kinds and the sticky overflow flag (a new loss wins over clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            kind_reg    <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            pending_reg <= (pending_reg & ~push_mask) | report;
            kind_reg    <= (kind_reg & ~report) | (key_state & report);
            ovf_reg     <= (ovf_reg & ~ovf_clr) | (|lost);
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= push_evt;
    end

    assign evt_data = evt_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign ovf      = ovf_reg;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based behavioural model of the event controller.
module tb_key_event_ctrl;

    localparam int N     = 4;
    localparam int D     = 16;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] key_in;
    logic         evt_valid;
    logic         evt_ready;
    logic [3:0]   evt_data;
    logic [N-1:0] key_state;
    logic         ovf;
    logic         ovf_clr;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    key_event_ctrl #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .key_state (key_state),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]   m_q[$];      // queued events, head first
    logic [3:0]   m_log[$];    // every event the consumer has taken
    bit [N-1:0]   m_state, m_pend, m_kind, m_armed, m_tog, m_last;
    bit [N-1:0]   m_s1, m_s2;  // raw key_in seen one and two edges ago
    int           m_run[N];    // length of the current run of equal samples
    int           m_edges;
    bit           m_ovf;
    bit           m_pop, m_push, m_lost;
    int           m_pidx;
    bit [N-1:0]   m_smp, m_newtog;

    function automatic bit reportable(input bit new_level);
`ifdef KEY_EVENT_RELEASE_EN
        return 1'b1;
`else
        return new_level;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_state = '0; m_pend = '0; m_kind = '0; m_armed = '0; m_tog = '0;
            m_last = '0; m_s1 = '1; m_s2 = '1; m_ovf = 1'b0; m_edges = 0;
            for (int k = 0; k < N; k++) m_run[k] = 0;
        end else begin
            // consumer and scheduler
            m_pop  = (m_q.size() > 0) && evt_ready;
            m_push = (m_pend != '0) && ((m_q.size() < DEPTH) || m_pop);
            m_pidx = 0;
            for (int k = N - 1; k >= 0; k--) if (m_pend[k]) m_pidx = k;
            if (m_pop) m_log.push_back(m_q.pop_front());
            if (m_push) begin
                m_q.push_back({m_kind[m_pidx], 3'(m_pidx)});
                m_pend[m_pidx] = 1'b0;
            end
            // last cycle's debounced changes become pending events
            m_lost = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (m_tog[k] && reportable(m_state[k])) begin
                    if (m_pend[k]) m_lost = 1'b1;
                    m_pend[k] = 1'b1;
                    m_kind[k] = m_state[k];
                end
            end
            m_ovf = (m_ovf && !ovf_clr) || m_lost;
            // debounce: accept a level once D consecutive samples disagree with it
            if (m_edges < 100) m_edges++;
            m_smp = ~m_s2;
            m_s2  = m_s1;
            m_s1  = key_in;
            for (int k = 0; k < N; k++) begin
                bit arm;
                if (m_smp[k] == m_last[k]) m_run[k] = (m_run[k] < D) ? m_run[k] + 1 : D;
                else                       m_run[k] = 1;
                m_last[k]   = m_smp[k];
                m_newtog[k] = 1'b0;
                arm = (m_edges >= 3) && !m_state[k] && !m_smp[k];
                if ((m_smp[k] != m_state[k]) && (m_run[k] >= D)) begin
                    m_state[k]  = m_smp[k];
                    m_newtog[k] = m_armed[k];
                end
                if (arm) m_armed[k] = 1'b1;
            end
            m_tog = m_newtog;
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("key_state", 32'(key_state), 32'(m_state));
            chk("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            if (m_q.size() > 0) chk("evt_data", 32'(evt_data), 32'(m_q[0]));
        end
    end

    // ---------------- stimulus ----------------
    int hold_left[N];
    logic [3:0] exp6 [6];

    initial begin
        rst_n = 1'b1; key_in = '1; evt_ready = 1'b0; ovf_clr = 1'b0;
        #2 rst_n = 1'b0;
        cyc(3);
        chk("rst_key_state", 32'(key_state), 32'h0);
        chk("rst_evt_valid", 32'(evt_valid), 32'h0);
        chk("rst_evt_data", 32'(evt_data), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        cyc(10);

        // Clean press of key 2: event appears D+4 cycles after key_in changes.
        key_in[2] = 1'b0;
        cyc(19);
        chk("lat_not_yet", 32'(evt_valid), 32'h0);
        cyc(1);
        chk("lat_valid", 32'(evt_valid), 32'h1);
        chk("lat_data", 32'(evt_data), 32'hA);
        chk("lat_key_state", 32'(key_state), 32'h4);
        $display("[TB] clean press key2: valid=%0b data=%b", evt_valid, evt_data);
        evt_ready = 1'b1;
        cyc(2);
        key_in[2] = 1'b1;
        cyc(30);

        // Key 0 bounces every 5 cycles then settles pressed: one press event.
        m_log.delete();
        for (int i = 0; i < 12; i++) begin
            key_in[0] = ~key_in[0];
            cyc(5);
        end
        key_in[0] = 1'b0;
        cyc(40);
        chk("bounce_count", 32'(m_log.size()), 32'd1);
        if (m_log.size() == 1) chk("bounce_evt", 32'(m_log[0]), 32'h8);
        $display("[TB] bounce key0: %0d event(s)", m_log.size());
        key_in[0] = 1'b1;
        cyc(30);

        // Keys 1 and 3 settle together: index 1 then index 3.
        m_log.delete();
        key_in[1] = 1'b0; key_in[3] = 1'b0;
        cyc(30);
        chk("pair_count", 32'(m_log.size()), 32'd2);
        if (m_log.size() == 2) begin
            chk("pair_first", 32'(m_log[0]), 32'h9);
            chk("pair_second", 32'(m_log[1]), 32'hB);
        end
        $display("[TB] keys 1+3 together: %0d event(s)", m_log.size());
        // Release of keys 1 and 3.
        key_in[1] = 1'b1; key_in[3] = 1'b1;
        cyc(30);
        chk("release_key_state", 32'(key_state), 32'h0);
`ifdef KEY_EVENT_RELEASE_EN
        chk("release_count", 32'(m_log.size()), 32'd4);
        if (m_log.size() == 4) begin
            chk("release_first", 32'(m_log[2]), 32'h1);
            chk("release_second", 32'(m_log[3]), 32'h3);
        end
`else
        chk("release_count", 32'(m_log.size()), 32'd2);
`endif
        $display("[TB] release keys 1+3: %0d event(s) total", m_log.size());

        // Six presses with the consumer stalled: four queued, two pending.
        evt_ready = 1'b0;
        m_log.delete();
        for (int k = 0; k < N; k++) begin
            key_in[k] = 1'b0;
            cyc(3);
        end
        cyc(30);
        chk("stall_queued", 32'(m_q.size()), 32'd4);
        key_in[0] = 1'b1; key_in[1] = 1'b1;
        cyc(30);
        key_in[0] = 1'b0; key_in[1] = 1'b0;
        cyc(30);
        chk("stall_pending", 32'(m_pend), 32'h3);
`ifdef KEY_EVENT_RELEASE_EN
        chk("stall_ovf", 32'(ovf), 32'h1);
`else
        chk("stall_ovf", 32'(ovf), 32'h0);
`endif
        evt_ready = 1'b1;
        cyc(20);
        exp6[0] = 4'h8; exp6[1] = 4'h9; exp6[2] = 4'hA;
        exp6[3] = 4'hB; exp6[4] = 4'h8; exp6[5] = 4'h9;
        chk("drain_count", 32'(m_log.size()), 32'd6);
        if (m_log.size() == 6)
            for (int i = 0; i < 6; i++) chk("drain_order", 32'(m_log[i]), 32'(exp6[i]));
        $display("[TB] stalled presses drained: %0d event(s)", m_log.size());

        // Re-toggle a key while its event is still pending: ovf, then clear.
        key_in = '1;
        cyc(30);
        evt_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            key_in[k] = 1'b0;
            cyc(3);
        end
        cyc(30);
        key_in[0] = 1'b1; cyc(30);
        key_in[0] = 1'b0; cyc(30);
        key_in[0] = 1'b1; cyc(30);
        key_in[0] = 1'b0; cyc(30);
        chk("ovf_set", 32'(ovf), 32'h1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'h0);
        $display("[TB] overflow on re-toggle, cleared: ovf=%0b", ovf);
        evt_ready = 1'b1;
        key_in = '1;
        cyc(40);

        // Reset with queued events and keys held: silent until released and re-pressed.
        evt_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            key_in[k] = 1'b0;
            cyc(3);
        end
        cyc(30);
        chk("pre_reset_queued", 32'(m_q.size()), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("reset_evt_valid", 32'(evt_valid), 32'h0);
        cyc(1);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        m_log.delete();
        cyc(60);
        chk("held_no_event", 32'(m_log.size()), 32'd0);
        chk("held_key_state", 32'(key_state), 32'h7);
        key_in = '1;
        cyc(40);
        chk("held_release_no_event", 32'(m_log.size()), 32'd0);
        key_in[2] = 1'b0;
        cyc(30);
        chk("repress_count", 32'(m_log.size()), 32'd1);
        if (m_log.size() == 1) chk("repress_evt", 32'(m_log[0]), 32'hA);
        $display("[TB] reset with held keys: %0d event(s) after re-press", m_log.size());
        key_in = '1;
        cyc(30);

        // Randomized phase: bounces, long holds, random backpressure, clears and resets.
        for (int k = 0; k < N; k++) hold_left[k] = $urandom_range(1, 40);
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (hold_left[k] == 0) begin
                    key_in[k] = ~key_in[k];
                    hold_left[k] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 10)
                                                              : $urandom_range(16, 60);
                end else begin
                    hold_left[k]--;
                end
            end
            evt_ready = ($urandom_range(0, 99) < 55);
            ovf_clr   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 799) == 0) begin
                rst_n = 1'b0;
                cyc(1);
                rst_n = 1'b1;
            end
            cyc(1);
        end
        ovf_clr = 1'b0;
        evt_ready = 1'b1;
        key_in = '1;
        cyc(60);
        $display("[TB] random phase done: %0d events consumed", m_log.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
